psr_controller: RTL and testbench
=================================

PSR_CONTROLLER -- requirements
Module: psr_controller

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, number of shadow-stack entries for interrupt save/restore (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port alu_valid  input  1  ALU result flags valid this cycle.
REQ-005 SHALL have port alu_flags  input  5  new flags {C,Z,L,F,N}, bit4=C .. bit0=N.
REQ-006 SHALL have port flag_mask  input  5  per-flag write enable, same bit order.
REQ-007 SHALL have port cond_req  input  1  request condition evaluation.
REQ-008 SHALL have port cond_code  input  4  condition selector.
REQ-009 SHALL have port irq_enter  input  1  interrupt entry pulse.
REQ-010 SHALL have port irq_exit  input  1  interrupt return pulse.
REQ-011 SHALL have port psr_out  output  5  current flags {C,Z,L,F,N}.
REQ-012 SHALL have port cond_valid  output  1  cond_true valid.
REQ-013 SHALL have port cond_true  output  1  evaluated condition.
REQ-014 SHALL have port busy  output  1  save/restore in progress; upstream stalls.
REQ-015 SHALL have port stack_ovf  output  1  sticky push-on-full error.
REQ-016 SHALL have port stack_unf  output  1  sticky pop-on-empty error.

Function
REQ-017 SHALL update flags on alu_valid in RUN: psr <= (psr & ~flag_mask) | (alu_flags & flag_mask), visible on psr_out next cycle.
REQ-018 SHALL register condition result: cond_req in cycle N -> cond_valid=1 with cond_true in cycle N+1, cond_valid=0 otherwise.
REQ-019 SHALL evaluate against the merged flags when alu_valid and cond_req coincide (bypass), else against psr.
REQ-020 SHALL decode cond_code: 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0; 4 HI L=1; 5 LS L=0; 6 GT N=1; 7 LE N=0; 8 FS F=1; 9 FC F=0; 10 LO L=0&Z=0; 11 HS L=1|Z=1; 12 LT N=0&Z=0; 13 GE N=1|Z=1; 14 UC always 1; 15 NV always 0.
REQ-021 SHALL implement FSM states RUN, SAVE, RESTORE; busy=1 exactly in SAVE and RESTORE.
REQ-022 SHALL go RUN->SAVE on irq_enter: in SAVE push merged psr (including same-cycle alu_valid update), clear psr to 0, return to RUN next cycle.
REQ-023 SHALL go RUN->RESTORE on irq_exit: in RESTORE pop top entry into psr, return to RUN next cycle.
REQ-024 SHALL give irq_enter priority over irq_exit when simultaneous; irq_exit dropped.
REQ-025 SHALL ignore alu_valid, irq_enter, irq_exit while busy; cond_req still served against psr.
REQ-026 SHALL on push when full drop the push, set stack_ovf, still clear psr.
REQ-027 SHALL on pop when empty leave psr unchanged, set stack_unf.
REQ-028 SHALL keep stack pointer within 0..STACK_DEPTH, no wrap-around.

Reset
REQ-029 SHALL on reset low immediately force psr_out=0, cond_valid=0, cond_true=0, busy=0, stack_ovf=0, stack_unf=0, stack empty, FSM=RUN; reset mid-SAVE/RESTORE aborts it.
REQ-030 SHALL clear stack_ovf/stack_unf only by reset.

Configuration
REQ-031 SHALL, with PSR_SHADOW_STACK_EN defined, implement the STACK_DEPTH-entry stack per REQ-022..028.
REQ-032 SHALL, without PSR_SHADOW_STACK_EN, use a single shadow register (depth 1): second irq_enter before irq_exit sets stack_ovf; STACK_DEPTH ignored.

Structure
REQ-033 SHALL place flag bit indices, cond_code constants and FSM state encoding in shared package psr_pkg.
REQ-034 SHALL implement condition decode as combinational sub-module psr_cond_eval.

Verification
REQ-035 SHALL test masked update: psr=0, alu_flags=5'b11111, mask=5'b01010 -> psr_out=5'b01010 next cycle.
REQ-036 SHALL test bypass: psr=0, alu_valid with Z set, same-cycle cond_req EQ -> cond_true=1 next cycle.
REQ-037 SHALL test nesting: psr=5'b10001, irq_enter -> busy 1 cycle, psr=0; psr=5'b00100, irq_enter; two irq_exit -> psr 5'b00100 then 5'b10001.
REQ-038 SHALL test overflow/underflow: 5 irq_enter at depth 4 -> stack_ovf=1; then 5 irq_exit -> stack_unf=1, psr unchanged on 5th.
REQ-039 SHALL test simultaneous irq_enter+irq_exit -> SAVE only, stack depth +1.
REQ-040 SHALL test reset asserted during SAVE -> all outputs 0 within same cycle, FSM RUN after release.

Source files
------------

// File: rtl/psr_pkg.sv
// Shared flag indices, condition codes and FSM encoding for the PSR controller.
// Optional shadow stack depth is selected with PSR_SHADOW_STACK_EN.
package psr_pkg;

   localparam int FLAG_W = 5;

   localparam int FLAG_N = 0;
   localparam int FLAG_F = 1;
   localparam int FLAG_L = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 4;

   typedef logic [FLAG_W-1:0] flags_t;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_HI = 4'd4;
   localparam logic [3:0] COND_LS = 4'd5;
   localparam logic [3:0] COND_GT = 4'd6;
   localparam logic [3:0] COND_LE = 4'd7;
   localparam logic [3:0] COND_FS = 4'd8;
   localparam logic [3:0] COND_FC = 4'd9;
   localparam logic [3:0] COND_LO = 4'd10;
   localparam logic [3:0] COND_HS = 4'd11;
   localparam logic [3:0] COND_LT = 4'd12;
   localparam logic [3:0] COND_GE = 4'd13;
   localparam logic [3:0] COND_UC = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2
   } state_t;

   function automatic flags_t merge_flags(
      input flags_t cur,
      input flags_t upd,
      input flags_t mask
   );
      return (cur & ~mask) | (upd & mask);
   endfunction

endpackage

// File: rtl/psr_cond_eval.sv
// Combinational condition-code decoder over the {C,Z,L,F,N} flags.
// Shadow stack selection (PSR_SHADOW_STACK_EN) does not affect this block.
module psr_cond_eval
   import psr_pkg::*;
(
   input  logic [FLAG_W-1:0] flags,
   input  logic [3:0]        code,
   output logic              result
);

   logic c, z, l, f, n;

   assign c = flags[FLAG_C];
   assign z = flags[FLAG_Z];
   assign l = flags[FLAG_L];
   assign f = flags[FLAG_F];
   assign n = flags[FLAG_N];

   always_comb begin
      result = 1'b0;
      unique case (code)
         COND_EQ: result = z;
         COND_NE: result = ~z;
         COND_CS: result = c;
         COND_CC: result = ~c;
         COND_HI: result = l;
         COND_LS: result = ~l;
         COND_GT: result = n;
         COND_LE: result = ~n;
         COND_FS: result = f;
         COND_FC: result = ~f;
         COND_LO: result = ~l & ~z;
         COND_HS: result = l | z;
         COND_LT: result = ~n & ~z;
         COND_GE: result = n | z;
         COND_UC: result = 1'b1;
         COND_NV: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/psr_controller.sv
// Processor status register with condition evaluation and interrupt shadow save.
// PSR_SHADOW_STACK_EN selects a STACK_DEPTH-entry stack; otherwise one register.
module psr_controller
   import psr_pkg::*;
#(
   parameter int STACK_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic [FLAG_W-1:0] flag_mask,
   input  logic              cond_req,
   input  logic [3:0]        cond_code,
   input  logic              irq_enter,
   input  logic              irq_exit,
   output logic [FLAG_W-1:0] psr_out,
   output logic              cond_valid,
   output logic              cond_true,
   output logic              busy,
   output logic              stack_ovf,
   output logic              stack_unf
);

`ifdef PSR_SHADOW_STACK_EN
   localparam int DEPTH = STACK_DEPTH;
`else
   // Single shadow register; the parameter has no effect here.
   localparam int DEPTH = STACK_DEPTH - STACK_DEPTH + 1;
`endif
   localparam int SPW = $clog2(DEPTH + 1);

   state_t         state, state_n;
   flags_t         psr, psr_n, merged, eval_flags, top;
   flags_t         stack [DEPTH];
   logic [SPW-1:0] sp;
   logic           push, pop, full, empty, cond_res;

   assign full  = (sp == SPW'(DEPTH));
   assign empty = (sp == '0);

   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp == SPW'(i + 1)) top = stack[i];
      end
   end

   assign merged = alu_valid ? merge_flags(psr, alu_flags, flag_mask) : psr;

   // Bypass only applies in RUN; while busy the ALU is ignored.
   assign eval_flags = (state == ST_RUN) ? merged : psr;

   psr_cond_eval u_cond (
      .flags  (eval_flags),
      .code   (cond_code),
      .result (cond_res)
   );

   always_comb begin
      state_n = state;
      psr_n   = psr;
      push    = 1'b0;
      pop     = 1'b0;
      unique case (state)
         ST_RUN: begin
            psr_n = merged;
            if (irq_enter)     state_n = ST_SAVE;
            else if (irq_exit) state_n = ST_RESTORE;
         end
         ST_SAVE: begin
            push    = 1'b1;
            psr_n   = '0;
            state_n = ST_RUN;
         end
         ST_RESTORE: begin
            pop     = 1'b1;
            if (!empty) psr_n = top;
            state_n = ST_RUN;
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_RUN;
         psr        <= '0;
         cond_valid <= 1'b0;
         cond_true  <= 1'b0;
      end else begin
         state      <= state_n;
         psr        <= psr_n;
         cond_valid <= cond_req;
         cond_true  <= cond_req & cond_res;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sp        <= '0;
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
         for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      end else begin
         if (push) begin
            if (full) begin
               stack_ovf <= 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (sp == SPW'(i)) stack[i] <= psr;
               end
               sp <= sp + SPW'(1);
            end
         end
         if (pop) begin
            if (empty) stack_unf <= 1'b1;
            else       sp <= sp - SPW'(1);
         end
      end
   end

   assign psr_out = psr;
   assign busy    = (state != ST_RUN);

endmodule

// File: tb/tb_psr_controller.sv
// Directed bench for psr_controller; expectations follow the build's stack depth.
module tb_psr_controller;

`ifdef PSR_SHADOW_STACK_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       alu_valid;
   logic [4:0] alu_flags;
   logic [4:0] flag_mask;
   logic       cond_req;
   logic [3:0] cond_code;
   logic       irq_enter;
   logic       irq_exit;
   logic [4:0] psr_out;
   logic       cond_valid;
   logic       cond_true;
   logic       busy;
   logic       stack_ovf;
   logic       stack_unf;

   int passed = 0;
   int total  = 0;

   psr_controller #(.STACK_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_flags  (alu_flags),
      .flag_mask  (flag_mask),
      .cond_req   (cond_req),
      .cond_code  (cond_code),
      .irq_enter  (irq_enter),
      .irq_exit   (irq_exit),
      .psr_out    (psr_out),
      .cond_valid (cond_valid),
      .cond_true  (cond_true),
      .busy       (busy),
      .stack_ovf  (stack_ovf),
      .stack_unf  (stack_unf)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #3;
      reset = 1'b1;
      step();
   endtask

   task automatic set_psr(input logic [4:0] v);
      alu_valid = 1'b1;
      alu_flags = v;
      flag_mask = 5'b11111;
      step();
      alu_valid = 1'b0;
   endtask

   task automatic enter();
      irq_enter = 1'b1;
      step();
      irq_enter = 1'b0;
      step();
   endtask

   task automatic leave();
      irq_exit = 1'b1;
      step();
      irq_exit = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      alu_valid = 0; alu_flags = 0; flag_mask = 0;
      cond_req = 0; cond_code = 0; irq_enter = 0; irq_exit = 0;
      #12;
      total++; if (psr_out !== 5'b0) $display("FAIL reset_psr got=%b exp=00000", psr_out); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
      total++; if (cond_valid !== 1'b0) $display("FAIL reset_cv got=%b exp=0", cond_valid); else passed++;
      total++; if ({stack_ovf, stack_unf} !== 2'b00) $display("FAIL reset_sticky got=%b exp=00", {stack_ovf, stack_unf}); else passed++;
      reset = 1'b1;
      step();
   endtask

   task automatic test_masked();
      set_psr(5'b00000);
      alu_valid = 1'b1; alu_flags = 5'b11111; flag_mask = 5'b01010;
      step();
      alu_valid = 1'b0;
      total++; if (psr_out !== 5'b01010) $display("FAIL masked got=%b exp=01010", psr_out); else passed++;
      alu_valid = 1'b1; alu_flags = 5'b00000; flag_mask = 5'b00010;
      step();
      alu_valid = 1'b0;
      total++; if (psr_out !== 5'b01000) $display("FAIL masked_clr got=%b exp=01000", psr_out); else passed++;
   endtask

   task automatic test_cond();
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      exp_a = 16'h5A96;
      exp_b = 16'h6969;
      set_psr(5'b10100);
      for (int i = 0; i < 16; i++) begin
         cond_req = 1'b1; cond_code = 4'(i);
         step();
         total++; if (cond_valid !== 1'b1 || cond_true !== exp_a[i]) $display("FAIL cond_a code=%0d got=%b/%b exp=1/%b", i, cond_valid, cond_true, exp_a[i]); else passed++;
      end
      cond_req = 1'b0;
      step();
      total++; if (cond_valid !== 1'b0) $display("FAIL cond_idle got=%b exp=0", cond_valid); else passed++;
      set_psr(5'b01011);
      for (int i = 0; i < 16; i++) begin
         cond_req = 1'b1; cond_code = 4'(i);
         step();
         total++; if (cond_true !== exp_b[i]) $display("FAIL cond_b code=%0d got=%b exp=%b", i, cond_true, exp_b[i]); else passed++;
      end
      cond_req = 1'b0;
      step();
   endtask

   task automatic test_bypass();
      set_psr(5'b00000);
      alu_valid = 1'b1; alu_flags = 5'b01000; flag_mask = 5'b01000;
      cond_req = 1'b1; cond_code = 4'd0;
      step();
      alu_valid = 1'b0; cond_req = 1'b0;
      total++; if (cond_true !== 1'b1) $display("FAIL bypass got=%b exp=1", cond_true); else passed++;
      total++; if (psr_out !== 5'b01000) $display("FAIL bypass_psr got=%b exp=01000", psr_out); else passed++;
   endtask

   task automatic test_nesting();
      do_reset();
      set_psr(5'b10001);
      irq_enter = 1'b1;
      step();
      irq_enter = 1'b0;
      alu_valid = 1'b1; alu_flags = 5'b11111; flag_mask = 5'b11111;
      total++; if (busy !== 1'b1) $display("FAIL nest_busy got=%b exp=1", busy); else passed++;
      step();
      alu_valid = 1'b0;
      total++; if (busy !== 1'b0 || psr_out !== 5'b0) $display("FAIL nest_clear got=%b/%b exp=0/00000", busy, psr_out); else passed++;
      set_psr(5'b00100);
      enter();
      total++; if (stack_ovf !== (DEPTH < 2)) $display("FAIL nest_ovf got=%b exp=%b", stack_ovf, DEPTH < 2); else passed++;
      leave();
`ifdef PSR_SHADOW_STACK_EN
      total++; if (psr_out !== 5'b00100) $display("FAIL nest_pop1 got=%b exp=00100", psr_out); else passed++;
`else
      total++; if (psr_out !== 5'b10001) $display("FAIL nest_pop1 got=%b exp=10001", psr_out); else passed++;
`endif
      leave();
      total++; if (psr_out !== 5'b10001) $display("FAIL nest_pop2 got=%b exp=10001", psr_out); else passed++;
      total++; if (stack_unf !== (DEPTH < 2)) $display("FAIL nest_unf got=%b exp=%b", stack_unf, DEPTH < 2); else passed++;
   endtask

   task automatic test_ovf_unf();
      do_reset();
      set_psr(5'b00011);
      for (int i = 0; i < DEPTH; i++) enter();
      total++; if (stack_ovf !== 1'b0) $display("FAIL ovf_early got=%b exp=0", stack_ovf); else passed++;
      enter();
      total++; if (stack_ovf !== 1'b1) $display("FAIL ovf got=%b exp=1", stack_ovf); else passed++;
      total++; if (psr_out !== 5'b0) $display("FAIL ovf_psr got=%b exp=00000", psr_out); else passed++;
      for (int i = 0; i < DEPTH; i++) leave();
      total++; if (psr_out !== 5'b00011 || stack_unf !== 1'b0) $display("FAIL unf_early got=%b/%b exp=00011/0", psr_out, stack_unf); else passed++;
      leave();
      total++; if (stack_unf !== 1'b1) $display("FAIL unf got=%b exp=1", stack_unf); else passed++;
      total++; if (psr_out !== 5'b00011) $display("FAIL unf_psr got=%b exp=00011", psr_out); else passed++;
      total++; if (stack_ovf !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", stack_ovf); else passed++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      set_psr(5'b00110);
      irq_enter = 1'b1; irq_exit = 1'b1;
      step();
      irq_enter = 1'b0; irq_exit = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL simul_busy got=%b exp=1", busy); else passed++;
      step();
      total++; if (psr_out !== 5'b0 || stack_unf !== 1'b0) $display("FAIL simul_save got=%b/%b exp=00000/0", psr_out, stack_unf); else passed++;
      leave();
      total++; if (psr_out !== 5'b00110 || stack_unf !== 1'b0) $display("FAIL simul_depth got=%b/%b exp=00110/0", psr_out, stack_unf); else passed++;
   endtask

   task automatic test_reset_mid_save();
      do_reset();
      set_psr(5'b11111);
      irq_enter = 1'b1; cond_req = 1'b1; cond_code = 4'd14;
      step();
      irq_enter = 1'b0; cond_req = 1'b0;
      total++; if (busy !== 1'b1 || cond_valid !== 1'b1) $display("FAIL mid_pre got=%b/%b exp=1/1", busy, cond_valid); else passed++;
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || psr_out !== 5'b0) $display("FAIL mid_reset got=%b/%b exp=0/00000", busy, psr_out); else passed++;
      total++; if (cond_valid !== 1'b0 || cond_true !== 1'b0) $display("FAIL mid_cond got=%b/%b exp=0/0", cond_valid, cond_true); else passed++;
      #1;
      reset = 1'b1;
      step();
      total++; if (busy !== 1'b0 || psr_out !== 5'b0) $display("FAIL mid_after got=%b/%b exp=0/00000", busy, psr_out); else passed++;
      set_psr(5'b00101);
      total++; if (psr_out !== 5'b00101) $display("FAIL mid_run got=%b exp=00101", psr_out); else passed++;
   endtask

   initial begin
      test_reset();
      test_masked();
      test_cond();
      test_bypass();
      test_nesting();
      test_ovf_unf();
      test_simultaneous();
      test_reset_mid_save();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
